// File: rtl/synapse_spike_scheduler_pkg.sv
// Shared definitions for the synapse spike scheduler: FSM state encoding and
// default sizing constants for the attached synapse array.
package snn_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CFG       = 2'd1,
    ST_ISSUE     = 2'd2,
    ST_WAIT_DONE = 2'd3
  } sched_state_e;

  localparam int DEF_NUM_SRC       = 2;
  localparam int DEF_NUM_AXONS     = 64;
  localparam int DEF_NUM_NEURONS   = 64;
  localparam int DEF_WEIGHT_WIDTH  = 8;
  localparam int DEF_FIFO_DEPTH    = 16;
  localparam int DEF_ISSUE_TIMEOUT = 8;

endpackage

// File: rtl/spike_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two so the
// read/write pointers wrap naturally.
module spike_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_full,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/synapse_spike_scheduler.sv
// Front end for synapse_array: round-robin spike arbitration into a FIFO, one
// spike in flight at a time, weight writes serialised between fan-outs.
// Define SCHED_STATS_EN to add the stat_issued / stat_full_cycles counters.
// Handshake: a source transfers on a cycle where src_valid[k] & src_ready[k];
// a config write is taken on a cycle where cfg_we & cfg_ready.
module synapse_spike_scheduler
  import snn_sched_pkg::*;
#(
  parameter int NUM_SRC         = DEF_NUM_SRC,
  parameter int NUM_AXONS       = DEF_NUM_AXONS,
  parameter int AXON_ID_WIDTH   = $clog2(NUM_AXONS),
  parameter int NUM_NEURONS     = DEF_NUM_NEURONS,
  parameter int NEURON_ID_WIDTH = $clog2(NUM_NEURONS),
  parameter int WEIGHT_WIDTH    = DEF_WEIGHT_WIDTH,
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
  parameter int ISSUE_TIMEOUT   = DEF_ISSUE_TIMEOUT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic [NUM_SRC-1:0]               src_valid,
  input  logic [NUM_SRC*AXON_ID_WIDTH-1:0] src_axon_id,
  output logic [NUM_SRC-1:0]               src_ready,
  input  logic                             cfg_we,
  input  logic [AXON_ID_WIDTH-1:0]         cfg_axon,
  input  logic [NEURON_ID_WIDTH-1:0]       cfg_neuron,
  input  logic [WEIGHT_WIDTH:0]            cfg_data,
  output logic                             cfg_ready,
  output logic                             sa_spike_valid,
  output logic [AXON_ID_WIDTH-1:0]         sa_spike_axon_id,
  input  logic                             sa_busy,
  output logic                             sa_weight_we,
  output logic [AXON_ID_WIDTH-1:0]         sa_weight_addr_axon,
  output logic [NEURON_ID_WIDTH-1:0]       sa_weight_addr_neuron,
  output logic [WEIGHT_WIDTH:0]            sa_weight_data,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
  output logic                             timeout_err,
`ifdef SCHED_STATS_EN
  output logic [31:0]                      stat_issued,
  output logic [31:0]                      stat_full_cycles,
`endif
  output sched_state_e                     dbg_state
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int TW = $clog2(ISSUE_TIMEOUT + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  sched_state_e               r_state;
  sched_state_e               w_next_state;
  logic [PW-1:0]              r_rr_ptr;
  logic [AXON_ID_WIDTH-1:0]   r_issue_axon;
  logic [TW-1:0]              r_to_cnt;
  logic                       r_timeout_err;
  logic [AXON_ID_WIDTH-1:0]   r_cfg_axon;
  logic [NEURON_ID_WIDTH-1:0] r_cfg_neuron;
  logic [WEIGHT_WIDTH:0]      r_cfg_data;

  logic [NUM_SRC-1:0]         w_mask;
  logic [NUM_SRC-1:0]         w_req_hi;
  logic [NUM_SRC-1:0]         w_pick_src;
  logic [NUM_SRC-1:0]         w_grant;
  logic [PW-1:0]              w_grant_idx;
  logic [AXON_ID_WIDTH-1:0]   w_push_data;
  logic [AXON_ID_WIDTH-1:0]   w_fifo_head;
  logic [CW-1:0]              w_fifo_count;
  logic                       w_fifo_empty;
  logic                       w_fifo_full;
  logic                       w_pop;
  logic                       w_cfg_accept;
  logic                       w_timeout_hit;

  // Round robin: prefer requesters at or above the pointer, else wrap to the lowest.
  assign w_mask     = ~((NUM_SRC'(1) << r_rr_ptr) - NUM_SRC'(1));
  assign w_req_hi   = src_valid & w_mask;
  assign w_pick_src = (|w_req_hi) ? w_req_hi : src_valid;

  always_comb begin
    w_grant = '0;
    if (!rst && enable && !w_fifo_full)
      w_grant = w_pick_src & (~w_pick_src + NUM_SRC'(1));
  end

  always_comb begin
    w_grant_idx = '0;
    w_push_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_grant[i]) begin
        w_grant_idx = PW'(i);
        w_push_data = src_axon_id[i*AXON_ID_WIDTH +: AXON_ID_WIDTH];
      end
    end
  end

  spike_fifo #(
    .WIDTH (AXON_ID_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (|w_grant),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_fifo_head),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_count (w_fifo_count)
  );

  // Config writes win over spikes in IDLE so weights never change mid fan-out.
  always_comb begin
    w_next_state  = r_state;
    w_pop         = 1'b0;
    w_cfg_accept  = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cfg_we) begin
          w_cfg_accept = 1'b1;
          w_next_state = ST_CFG;
        end else if (enable && !w_fifo_empty && !sa_busy) begin
          w_pop        = 1'b1;
          w_next_state = ST_ISSUE;
        end
      end
      ST_CFG:   w_next_state = ST_IDLE;
      ST_ISSUE: begin
        if (sa_busy) begin
          w_next_state = ST_WAIT_DONE;
        end else if (r_to_cnt == TW'(ISSUE_TIMEOUT - 1)) begin
          w_timeout_hit = 1'b1;
          w_next_state  = ST_IDLE;
        end
      end
      ST_WAIT_DONE: if (!sa_busy) w_next_state = ST_IDLE;
      default:      w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_rr_ptr      <= '0;
      r_issue_axon  <= '0;
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
      r_cfg_axon    <= '0;
      r_cfg_neuron  <= '0;
      r_cfg_data    <= '0;
    end else begin
      r_state <= w_next_state;
      if (|w_grant)
        r_rr_ptr <= (w_grant_idx == PW'(NUM_SRC - 1)) ? '0 : w_grant_idx + 1'b1;
      if (w_pop) begin
        r_issue_axon <= w_fifo_head;
        r_to_cnt     <= '0;
      end else if (r_state == ST_ISSUE) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (w_timeout_hit) r_timeout_err <= 1'b1;
      if (w_cfg_accept) begin
        r_cfg_axon   <= cfg_axon;
        r_cfg_neuron <= cfg_neuron;
        r_cfg_data   <= cfg_data;
      end
    end
  end

  // cfg_ready is masked by rst so every output reads 0 while reset is held.
  assign src_ready             = w_grant;
  assign cfg_ready             = (r_state == ST_IDLE) && !rst;
  assign sa_spike_valid        = (r_state == ST_ISSUE);
  assign sa_spike_axon_id      = r_issue_axon;
  assign sa_weight_we          = (r_state == ST_CFG);
  assign sa_weight_addr_axon   = r_cfg_axon;
  assign sa_weight_addr_neuron = r_cfg_neuron;
  assign sa_weight_data        = r_cfg_data;
  assign fifo_count            = w_fifo_count;
  assign timeout_err           = r_timeout_err;
  assign dbg_state             = r_state;

`ifdef SCHED_STATS_EN
  logic [31:0] r_stat_issued;
  logic [31:0] r_stat_full_cycles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_issued      <= '0;
      r_stat_full_cycles <= '0;
    end else begin
      if (r_state == ST_ISSUE && sa_busy && r_stat_issued != '1)
        r_stat_issued <= r_stat_issued + 32'd1;
      if (w_fifo_full && (|src_valid) && r_stat_full_cycles != '1)
        r_stat_full_cycles <= r_stat_full_cycles + 32'd1;
    end
  end

  assign stat_issued      = r_stat_issued;
  assign stat_full_cycles = r_stat_full_cycles;
`endif

endmodule

// File: tb/tb_synapse_spike_scheduler.sv
// Directed bench for synapse_spike_scheduler with a behavioural array model
// (busy raised 2 cycles after a spike, held 8 cycles) and an event monitor.
module tb_synapse_spike_scheduler;
  import snn_sched_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [1:0]   src_valid;
  logic [11:0]  src_axon_id;
  logic [1:0]   src_ready;
  logic         cfg_we;
  logic [5:0]   cfg_axon;
  logic [5:0]   cfg_neuron;
  logic [8:0]   cfg_data;
  logic         cfg_ready;
  logic         sa_spike_valid;
  logic [5:0]   sa_spike_axon_id;
  logic         sa_busy;
  logic         sa_weight_we;
  logic [5:0]   sa_weight_addr_axon;
  logic [5:0]   sa_weight_addr_neuron;
  logic [8:0]   sa_weight_data;
  logic [4:0]   fifo_count;
  logic         timeout_err;
  sched_state_e dbg_state;
`ifdef SCHED_STATS_EN
  logic [31:0]  stat_issued;
  logic [31:0]  stat_full_cycles;
`endif

  synapse_spike_scheduler dut (
    .clk                   (clk),
    .rst                   (rst),
    .enable                (enable),
    .src_valid             (src_valid),
    .src_axon_id           (src_axon_id),
    .src_ready             (src_ready),
    .cfg_we                (cfg_we),
    .cfg_axon              (cfg_axon),
    .cfg_neuron            (cfg_neuron),
    .cfg_data              (cfg_data),
    .cfg_ready             (cfg_ready),
    .sa_spike_valid        (sa_spike_valid),
    .sa_spike_axon_id      (sa_spike_axon_id),
    .sa_busy               (sa_busy),
    .sa_weight_we          (sa_weight_we),
    .sa_weight_addr_axon   (sa_weight_addr_axon),
    .sa_weight_addr_neuron (sa_weight_addr_neuron),
    .sa_weight_data        (sa_weight_data),
    .fifo_count            (fifo_count),
    .timeout_err           (timeout_err),
`ifdef SCHED_STATS_EN
    .stat_issued           (stat_issued),
    .stat_full_cycles      (stat_full_cycles),
`endif
    .dbg_state             (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1);
  end

  // Array model, driven on the falling edge
  logic model_on = 1'b0;
  int   m_wait   = 0;
  int   m_left   = 0;

  always @(negedge clk) begin
    if (!model_on) begin
      sa_busy = 1'b0;
      m_wait  = 0;
      m_left  = 0;
    end else if (m_left != 0) begin
      sa_busy = 1'b1;
      m_left  = m_left - 1;
    end else if (m_wait != 0) begin
      m_wait = m_wait - 1;
      if (m_wait == 0) begin
        sa_busy = 1'b1;
        m_left  = 7;
      end
    end else begin
      sa_busy = 1'b0;
      if (sa_spike_valid) m_wait = 1;
    end
  end

  // Monitor: issue episodes, weight writes, grants
  logic [5:0]  iss_q[$];
  int          len_q[$];
  logic [7:0]  ev_q[$];
  logic [20:0] wr_q[$];
  logic        gnt_q[$];
  logic        prev_valid = 1'b0;
  int          cur_len    = 0;

  always @(negedge clk) begin
    if (sa_spike_valid && !prev_valid) begin
      iss_q.push_back(sa_spike_axon_id);
      ev_q.push_back({2'b00, sa_spike_axon_id});
      cur_len = 1;
    end else if (sa_spike_valid) begin
      cur_len++;
    end else if (prev_valid) begin
      len_q.push_back(cur_len);
    end
    prev_valid = sa_spike_valid;
    if (sa_weight_we) begin
      wr_q.push_back({sa_weight_addr_axon, sa_weight_addr_neuron, sa_weight_data});
      ev_q.push_back(8'h80);
    end
    if (src_valid[0] && src_ready[0]) gnt_q.push_back(1'b0);
    if (src_valid[1] && src_ready[1]) gnt_q.push_back(1'b1);
  end

  // Scoreboard
  int         errors = 0;
  int         checks = 0;
  int         n;
  logic [5:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_issued(input string tag);
    check({tag, "_count"}, iss_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      check({tag, "_id"}, (k < iss_q.size()) ? 32'(iss_q[k]) : 32'hffff_ffff, 32'(exp_q[k]));
  endtask

  task automatic clear_logs();
    iss_q.delete(); len_q.delete(); ev_q.delete(); wr_q.delete(); gnt_q.delete(); exp_q.delete();
  endtask

  // Driver tasks
  task automatic cyc(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push1(input int src, input logic [5:0] id);
    src_valid = 2'b00;
    src_valid[src] = 1'b1;
    src_axon_id[src*6 +: 6] = id;
    cyc();
    src_valid = 2'b00;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int w = 0;
    while (!(dbg_state == ST_IDLE && fifo_count == 5'd0 && !sa_busy) && w < budget) begin
      cyc();
      w++;
    end
    check(tag, w < budget, 1);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; src_valid = 2'b11; src_axon_id = '0;
    cfg_we = 1'b0; cfg_axon = '0; cfg_neuron = '0; cfg_data = '0;
    sa_busy = 1'b0;
    cyc(2);
    #1;
    check("rst_fifo_count", fifo_count, 0);
    check("rst_src_ready", src_ready, 0);
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_spike_valid", sa_spike_valid, 0);
    check("rst_weight_we", sa_weight_we, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_state", dbg_state, ST_IDLE);
    src_valid = 2'b00;
    cyc();
    rst = 1'b0;
    cyc();
    check("idle_cfg_ready", cfg_ready, 1);

    // Step 1: one spike from source 1, axon 5
    model_on = 1'b1;
    src_valid = 2'b10; src_axon_id[11:6] = 6'd5;
    #1;
    check("t1_grant", src_ready, 2'b10);
    cyc();
    src_valid = 2'b00;
    check("t1_count_after_push", fifo_count, 1);
    wait_idle("t1_idle", 100);
    check("t1_episodes", iss_q.size(), 1);
    check("t1_axon", (iss_q.size() > 0) ? 32'(iss_q[0]) : 32'hffff_ffff, 5);
    check("t1_valid_len", (len_q.size() > 0) ? len_q[0] : -1, 2);
    check("t1_fifo_count", fifo_count, 0);
    check("t1_cfg_ready", cfg_ready, 1);

    // Step 2: both sources always valid, fill to full
    clear_logs();
    src_axon_id = {6'd2, 6'd1};
    src_valid   = 2'b11;
    n = 0;
    while (fifo_count != 5'd16 && n < 100) begin cyc(); n++; end
    check("t2_full_reached", fifo_count, 16);
    #1;
    check("t2_full_no_grant", src_ready, 2'b00);
    n = 0;
    while (fifo_count == 5'd16 && n < 60) begin
      check("t2_full_hold", src_ready, 2'b00);
      cyc();
      n++;
    end
    check("t2_popped", fifo_count, 15);
    check("t2_grant_resume", src_ready, (gnt_q.size() % 2 == 0) ? 2'b01 : 2'b10);
    src_valid = 2'b00;
    wait_idle("t2_drain", 800);
    check("t2_enough_pushes", iss_q.size() >= 17, 1);
    check("t2_grant_count", gnt_q.size(), iss_q.size());
    for (int k = 0; k < gnt_q.size(); k++) begin
      check("t2_grant_order", gnt_q[k], k % 2);
      exp_q.push_back((k % 2 == 0) ? 6'd1 : 6'd2);
    end
    check_issued("t2_issue");

    // Step 3: weight write requested during a fan-out
    clear_logs();
    push1(0, 6'd10);
    push1(0, 6'd11);
    n = 0;
    while (dbg_state != ST_WAIT_DONE && n < 50) begin cyc(); n++; end
    check("t3_wait_done", dbg_state, ST_WAIT_DONE);
    cfg_axon = 6'd3; cfg_neuron = 6'd7; cfg_data = {1'b1, 8'd100}; cfg_we = 1'b1;
    #1;
    check("t3_blocked", cfg_ready, 0);
    n = 0;
    while (dbg_state != ST_IDLE && n < 50) begin
      check("t3_blocked_loop", cfg_ready, 0);
      cyc();
      n++;
    end
    check("t3_ready_idle", cfg_ready, 1);
    cyc();
    cfg_we = 1'b0;
    check("t3_state_cfg", dbg_state, ST_CFG);
    check("t3_weight_we", sa_weight_we, 1);
    check("t3_addr_axon", sa_weight_addr_axon, 3);
    check("t3_addr_neuron", sa_weight_addr_neuron, 7);
    check("t3_data", sa_weight_data, 9'h164);
    wait_idle("t3_idle", 100);
    check("t3_events", ev_q.size(), 3);
    check("t3_ev0", (ev_q.size() > 0) ? 32'(ev_q[0]) : 32'hffff_ffff, 8'd10);
    check("t3_ev1", (ev_q.size() > 1) ? 32'(ev_q[1]) : 32'hffff_ffff, 8'h80);
    check("t3_ev2", (ev_q.size() > 2) ? 32'(ev_q[2]) : 32'hffff_ffff, 8'd11);
    check("t3_writes", wr_q.size(), 1);

    // Step 4: array never responds to the first spike
    clear_logs();
    model_on = 1'b0;
    push1(0, 6'd20);
    push1(0, 6'd21);
    n = 0;
    while (!timeout_err && n < 40) begin cyc(); n++; end
    check("t4_timeout_set", timeout_err, 1);
    check("t4_dropped_to_idle", dbg_state, ST_IDLE);
    model_on = 1'b1;
    wait_idle("t4_idle", 100);
    exp_q = '{6'd20, 6'd21};
    check_issued("t4_issue");
    check("t4_len_timeout", (len_q.size() > 0) ? len_q[0] : -1, 8);
    check("t4_len_normal", (len_q.size() > 1) ? len_q[1] : -1, 2);
    check("t4_sticky", timeout_err, 1);

    // Step 5: enable low with three spikes queued
    clear_logs();
    push1(0, 6'd30);
    push1(0, 6'd31);
    push1(0, 6'd32);
    push1(0, 6'd33);
    enable = 1'b0;
    check("t5_queued", fifo_count, 3);
    src_valid = 2'b01;
    #1;
    check("t5_no_grant", src_ready, 2'b00);
    src_valid = 2'b00;
    cyc(40);
    check("t5_held_issues", iss_q.size(), 1);
    check("t5_held_count", fifo_count, 3);
    check("t5_held_valid", sa_spike_valid, 0);
    enable = 1'b1;
    wait_idle("t5_idle", 200);
    exp_q = '{6'd30, 6'd31, 6'd32, 6'd33};
    check_issued("t5_issue");

    // Step 6: reset during a fan-out with four queued
    clear_logs();
    for (int k = 0; k < 5; k++) push1(0, 6'(40 + k));
    n = 0;
    while (dbg_state != ST_WAIT_DONE && n < 50) begin cyc(); n++; end
    check("t6_wait_done", dbg_state, ST_WAIT_DONE);
    check("t6_queued", fifo_count, 4);
    rst = 1'b1;
    #1;
    check("t6_rst_count", fifo_count, 0);
    check("t6_rst_state", dbg_state, ST_IDLE);
    check("t6_rst_cfg_ready", cfg_ready, 0);
    check("t6_rst_timeout", timeout_err, 0);
    check("t6_rst_valid", sa_spike_valid, 0);
    check("t6_rst_axon", sa_spike_axon_id, 0);
    model_on = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(30);
    check("t6_no_spurious", iss_q.size(), 1);
    check("t6_count_after", fifo_count, 0);
    check("t6_valid_after", sa_spike_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/synapse_spike_scheduler.md
Name: synapse_spike_scheduler

Overview:
Front-end controller for synapse_array. It arbitrates axon spike events from NUM_SRC requesters (e.g. external input stream, recurrent feedback) round-robin into a spike FIFO. It issues queued spikes to the array one at a time, waiting for each fan-out to finish before issuing the next. It also serialises weight-configuration writes so they never overlap an active fan-out.

Parameters:
NUM_SRC, 2, number of spike requesters
NUM_AXONS, 64, axon count of the attached array
AXON_ID_WIDTH, 6, clog2(NUM_AXONS)
NUM_NEURONS, 64, neuron count of the attached array
NEURON_ID_WIDTH, 6, clog2(NUM_NEURONS)
WEIGHT_WIDTH, 8, weight magnitude width; config data is WEIGHT_WIDTH+1 bits, MSB = exc(1)/inh(0)
FIFO_DEPTH, 16, spike FIFO entries (power of 2)
ISSUE_TIMEOUT, 8, cycles to wait for sa_busy after issue

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
enable  in  1  0 = hold: no issue, no arbitration; config writes still allowed
src_valid  in  NUM_SRC  per-source spike request
src_axon_id  in  NUM_SRC*AXON_ID_WIDTH  packed axon IDs, source k at [k*AW +: AW]
src_ready  out  NUM_SRC  one-hot grant; a transfer occurs when valid&ready
cfg_we  in  1  weight write request
cfg_axon  in  AXON_ID_WIDTH  write axon address
cfg_neuron  in  NEURON_ID_WIDTH  write neuron address
cfg_data  in  WEIGHT_WIDTH+1  {exc_inh, weight}
cfg_ready  out  1  write accepted this cycle when cfg_we&cfg_ready
sa_spike_valid  out  1  spike to array
sa_spike_axon_id  out  AXON_ID_WIDTH  axon ID to array
sa_busy  in  1  array fan-out in progress
sa_weight_we  out  1  registered write pulse to array
sa_weight_addr_axon  out  AXON_ID_WIDTH  write address
sa_weight_addr_neuron  out  NEURON_ID_WIDTH  write address
sa_weight_data  out  WEIGHT_WIDTH+1  write data
fifo_count  out  clog2(FIFO_DEPTH)+1  current occupancy
timeout_err  out  1  sticky; set on issue timeout, cleared by rst only

Behaviour:
- Reset (async, rst=1): all outputs 0, FIFO empty, state IDLE, RR pointer = source 0.
- Arbitration: src_ready asserted for at most one source per cycle. Selection is round-robin, starting at the source after the last grant. No grant when the FIFO is full or enable=0.
- Grant is combinational from src_valid, pointer and full. The push is registered, and fifo_count updates next cycle.
- FIFO: push and pop in the same cycle are allowed and leave the count unchanged. Pointers wrap modulo FIFO_DEPTH. Full means count==FIFO_DEPTH; no push is performed when full.
- FSM states: IDLE, CFG, ISSUE, WAIT_DONE.
  - IDLE: if cfg_we=1 -> cfg_ready=1, go to CFG (config has priority over spikes). Else if enable, FIFO non-empty and sa_busy=0 -> pop head into issue register, go to ISSUE.
  - CFG (1 cycle): drive sa_weight_we=1 with the registered address and data, then return to IDLE. Throughput is one write per 2 cycles.
  - ISSUE: sa_spike_valid=1, sa_spike_axon_id=issue register. Go to WAIT_DONE on sa_busy=1. After ISSUE_TIMEOUT cycles without busy: set timeout_err, drop the spike, go to IDLE.
  - WAIT_DONE: sa_spike_valid=0. Go to IDLE on sa_busy=0.
- cfg_ready=0 in every state except IDLE.
- Minimum spike-to-spike issue spacing: ISSUE(>=1) + WAIT_DONE(>=1) + IDLE(1).
- enable falling mid-fan-out: the current spike completes; no new pop.
- Reset mid-operation: the in-flight spike is abandoned and FIFO contents are lost.

Optional Feature:
SCHED_STATS_EN
- Defined: adds outputs stat_issued (32-bit, increments on each ISSUE->WAIT_DONE transition) and stat_full_cycles (32-bit, counts cycles with FIFO full while any src_valid=1). Both counters saturate at all-ones and reset to 0.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package snn_sched_pkg: FSM state encoding (IDLE=2'd0, CFG=2'd1, ISSUE=2'd2, WAIT_DONE=2'd3) and default width constants.
- One sub-module: spike_fifo (parameterised sync FIFO with count output).
- Arbiter and FSM stay in the top module.

Test Plan:
1. Single source pushes axon 5; array model asserts busy 2 cycles after valid, for 8 cycles -> exactly one sa_spike_valid episode with axon_id=5; fifo_count returns to 0; cfg_ready=1 in IDLE after completion.
2. Both sources hold valid continuously with IDs 1 and 2 -> grants alternate 0,1,0,1. Issued order is 1,2,1,2. Once FIFO full (count=16), src_ready=0 until a pop.
3. cfg_we asserted while WAIT_DONE -> cfg_ready=0 until busy falls. Then one sa_weight_we pulse with {1'b1,8'd100} at axon 3, neuron 7, before the next queued spike issues.
4. Array model never asserts busy -> sa_spike_valid high for 8 cycles, then timeout_err=1 and the spike is dropped. The next FIFO entry issues normally; timeout_err stays 1.
5. enable=0 with 3 spikes queued -> no sa_spike_valid and no grants. enable=1 -> the 3 spikes issue in FIFO order.
6. rst pulsed during WAIT_DONE with 4 queued -> all outputs 0 immediately; fifo_count=0; after release, no spurious issue.
